// File: rtl/sort_n_seq_pkg.sv
// Shared types and sizing helpers for the odd-even transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold the worst-case exchange count N*(N-1)/2.
  function automatic int scw_f(input int n);
    int max_swaps;
    max_swaps = n * (n - 1) / 2;
    return (max_swaps < 1) ? 1 : $clog2(max_swaps + 1);
  endfunction

  // Element 0 lives in the MSBs of the packed vector.
  function automatic int elem_lsb(input int i, input int n, input int w);
    return (n - 1 - i) * w;
  endfunction

endpackage

// File: rtl/sort_n_seq_if.sv
// Producer/consumer handshake bundle for sort_n_seq.
interface sort_n_seq_if
  import sort_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 3
) ();

  localparam int SCW = scw_f(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 desc;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WIDTH-1:0]   out_data;
  logic [SCW-1:0]       swap_cnt;

  modport master (
    output in_valid, in_data, desc, out_ready,
    input  in_ready, out_valid, out_data, swap_cnt
  );

  modport slave (
    input  in_valid, in_data, desc, out_ready,
    output in_ready, out_valid, out_data, swap_cnt
  );

endinterface

// File: rtl/sort_n_seq_cmp_swap.sv
// Combinational compare-exchange cell; lo_out feeds the left slot, hi_out the right.
module cmp_swap #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swapped
);

  // Strict compares keep equal elements in place, so the sort is stable.
  assign swapped = desc ? (a < b) : (a > b);
  assign lo_out  = swapped ? b : a;
  assign hi_out  = swapped ? a : b;

endmodule

// File: rtl/sort_n_seq.sv
// Multi-cycle odd-even transposition sorter: one pass per clock, early exit
// after two consecutive quiet passes, valid/ready on both sides.
module sort_n_seq
  import sort_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 3
) (
  input  logic       clk,
  input  logic       rst,
  sort_n_seq_if.slave bus
);

  localparam int SCW = scw_f(N);
  localparam int PW  = $clog2(N);
  localparam int NC  = N - 1;

  state_t             state, state_nxt;
  logic [N*WIDTH-1:0] data_r, data_nxt;
  logic               desc_r;
  logic [PW-1:0]      pass_r;
  logic               prev_zero_r;
  logic [SCW-1:0]     swap_cnt_r;
  logic [SCW-1:0]     pass_swaps;
  logic               finish;

  logic [WIDTH-1:0]   elem [N];
  logic [WIDTH-1:0]   lo   [NC];
  logic [WIDTH-1:0]   hi   [NC];
  logic [NC-1:0]      swapped;
  logic [NC-1:0]      active;

  for (genvar i = 0; i < N; i++) begin : g_elem
    assign elem[i] = data_r[elem_lsb(i, N, WIDTH) +: WIDTH];
  end

  // Even cells (0,1),(2,3).. run on even passes, odd cells on odd passes.
  for (genvar k = 0; k < NC; k++) begin : g_cell
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .a      (elem[k]),
      .b      (elem[k+1]),
      .desc   (desc_r),
      .lo_out (lo[k]),
      .hi_out (hi[k]),
      .swapped(swapped[k])
    );
    if ((k % 2) == 0) begin : g_even
      assign active[k] = ~pass_r[0];
    end else begin : g_odd
      assign active[k] = pass_r[0];
    end
  end

  always_comb begin
    data_nxt   = data_r;
    pass_swaps = '0;
    for (int k = 0; k < NC; k++) begin
      if (active[k]) begin
        data_nxt[elem_lsb(k, N, WIDTH) +: WIDTH]     = lo[k];
        data_nxt[elem_lsb(k + 1, N, WIDTH) +: WIDTH] = hi[k];
        if (swapped[k]) pass_swaps = pass_swaps + SCW'(1);
      end
    end
  end

  assign finish = (pass_r == PW'(N - 1)) ||
                  ((pass_r != '0) && prev_zero_r && (pass_swaps == '0));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SORT;
      SORT:    if (finish)        state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // ---- element registers, pass counter and swap accumulator ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r      <= '0;
      desc_r      <= 1'b0;
      pass_r      <= '0;
      prev_zero_r <= 1'b0;
      swap_cnt_r  <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      data_r      <= bus.in_data;
      desc_r      <= bus.desc;
      pass_r      <= '0;
      prev_zero_r <= 1'b0;
      swap_cnt_r  <= '0;
    end else if (state == SORT) begin
      data_r      <= data_nxt;
      swap_cnt_r  <= swap_cnt_r + pass_swaps;
      prev_zero_r <= (pass_swaps == '0);
      if (!finish) pass_r <= pass_r + PW'(1);
    end
  end

  assign bus.out_data = data_r;
  assign bus.swap_cnt = swap_cnt_r;

endmodule

// File: doc/sort_n_seq.md
# sort_n_seq

Parametrised, multi-cycle sorter for N unsigned WIDTH-bit elements, and the next generation of the 3-element `sort2` bubble sorter. It uses odd-even transposition (parallel bubble sort) and runs one pass per clock. Run-time ascending/descending mode, early termination, a swap counter and valid/ready handshakes on both sides let it sit between a producer and a consumer in a streaming datapath.

## Interface
- `WIDTH`, 3: element width in bits, at least 1.
- `N`, 3: number of elements, at least 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: producer offers `in_data`.
- `in_ready` output 1: block can accept a vector.
- `in_data` input N*WIDTH: element i at bits [(N-i)*WIDTH-1 -: WIDTH], so element 0 is in the MSBs (same order as {no1,no2,no3}).
- `desc` input 1: 0 = ascending (element 0 smallest), 1 = descending. Sampled with `in_data`.
- `out_valid` output 1: `out_data` and `swap_cnt` hold a finished result.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output N*WIDTH: sorted vector, same packing as `in_data`.
- `swap_cnt` output SCW: number of exchanges performed on this vector. SCW = clog2(N*(N-1)/2+1).

## Operation
- FSM states: IDLE, SORT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load element registers, latch `desc`, clear the pass counter, `swap_cnt` and the "previous pass had no swap" flag, then go to SORT.
- **SORT**, one pass per cycle, pass index p = 0..N-1:
  - Even p compares pairs (0,1), (2,3), ...
  - Odd p compares pairs (1,2), (3,4), ...
  - Ascending swaps when left > right. Descending swaps when left < right.
  - Equal elements never swap, so the sort is stable and duplicates are safe.
  - `swap_cnt` += number of swaps in the pass. It cannot overflow because the maximum is N*(N-1)/2.
  - Termination: go to DONE at the end of pass p if p = N-1, or if p ≥ 1 and both pass p and pass p-1 performed zero swaps.
  - A pass with no pairs, such as an odd pass with N=2, counts as a zero-swap pass.
- **DONE**
  - `out_valid`=1. `out_data` and `swap_cnt` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE. The two are never high together, and there is no input-to-output combinational path.
- `in_data` and `desc` are ignored outside IDLE.
- `out_data` is only meaningful while `out_valid`=1. During SORT it shows intermediate state.
- Comparison is unsigned over the full WIDTH.

## Timing
- Reset (asynchronous, any state, including mid-sort):
  - State goes to IDLE and the in-flight vector is discarded.
  - `out_valid`=0, `out_data`=0, `swap_cnt`=0.
  - `in_ready`=1 (decoded from IDLE, including while `rst` is held).
- Acceptance at rising edge E0 (`in_valid` & `in_ready`).
- Pass p executes at edge E0+p+1.
- With P passes executed (2 ≤ P ≤ N), `out_valid` rises after edge E0+P.
- Best-case latency is 2 cycles. Worst case is N cycles.
- Result handshake at edge E1 (`out_valid` & `out_ready`). `in_ready` is 1 in the following cycle, so back-to-back throughput is one vector per P+2 cycles.
- `out_ready` held low: the result stays stable indefinitely.

## Structure
- Package `sort_pkg` holds:
  - the state enum (IDLE, SORT, DONE);
  - a function computing SCW from N;
  - a function returning the element slice index.
- Sub-module `cmp_swap`: combinational compare-exchange cell.
  - Ports: `a`, `b` (WIDTH), `desc`; outputs `lo_out`, `hi_out` and `swapped`.
  - Instantiated N-1 times.
  - The top selects which cells are active by pass parity.
- The top holds the FSM, pass counter, element registers, zero-swap flag and `swap_cnt` adder.

## Test plan
- **Exhaustive compatibility.** WIDTH=3, N=3, `desc`=1, all 512 {a,b,c} combinations back-to-back with `out_ready`=1. Expect every `out_data` = {max, mid, min}, identical to the `sort2` golden file ans2.txt.
- **Ascending, worst case.** N=8, WIDTH=3, `desc`=0, input {7,6,5,4,3,2,1,0}. Expect `out_data`={0,1,...,7}, `swap_cnt`=28, `out_valid` high after E0+8.
- **Early exit.** N=8, input already ascending {0,1,...,7}, `desc`=0. Expect `swap_cnt`=0 and `out_valid` high after E0+2.
- **Duplicates, descending.** N=4, input {2,5,2,5}, `desc`=1. Expect `out_data`={5,5,2,2} and `swap_cnt`=3.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles after `out_valid`. Expect `out_data` and `swap_cnt` unchanged and `in_ready`=0 throughout, with a new `in_valid` ignored. Release: IDLE in the next cycle.
- **Reset mid-sort.** Assert `rst` at pass 2 of N=8. Expect `out_valid`=0, `out_data`=0, `swap_cnt`=0 immediately. After release, a fresh vector {3,1,2,0,...} sorts correctly.
